// File: rtl/axi_slave_mem_pkg.sv
// Shared definitions for the AXI4 slave word memory.
//   - AXI response / burst / size encodings used by both channels
//   - read and write channel FSM state encodings
//   - fmt_err(): flags a transfer format the memory cannot serve
package axi_slave_mem_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  // Only full-word INCR bursts are supported; anything else is answered with SLVERR.
  function automatic logic fmt_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != AXI_SIZE_4B) || (burst != AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_slave_mem_mem_1r1w.sv
// Simple dual-port word array: one synchronous write port, one read port with a
// registered output. A read and write to the same word in one cycle returns the
// old contents; the write still takes effect. The output register only updates
// when re is high, so the last read word is held otherwise.
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read request
//   rdata          registered read data
module mem_1r1w #(
  parameter int WORDS = 2048,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [WORDS];
  logic [WIDTH-1:0] rdata_q;

  // Contents are intentionally not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave word memory on the *_m_inf bus (slave side *_s_inf ports).
// Serves INCR read and write bursts of 32-bit words from a shared array.
// Read and write channels are independent FSMs.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   aw*_s_inf                write address channel (id, addr, len, size, burst, valid/ready)
//   w*_s_inf                 write data channel (data, last, valid/ready)
//   b*_s_inf                 write response channel (id, resp, valid/ready)
//   ar*_s_inf                read address channel
//   r*_s_inf                 read data channel (id, data, resp, last, valid/ready)
// Out-of-range beats (word index >= MEM_WORDS), unsupported size/burst and
// wlast/length mismatches are reported as SLVERR; addresses never wrap.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  // write address
  input  logic [ID_WIDTH-1:0]   awid_s_inf,
  input  logic [ADDR_WIDTH-1:0] awaddr_s_inf,
  input  logic [3:0]            awlen_s_inf,
  input  logic [2:0]            awsize_s_inf,
  input  logic [1:0]            awburst_s_inf,
  input  logic                  awvalid_s_inf,
  output logic                  awready_s_inf,
  // write data
  input  logic [DATA_WIDTH-1:0] wdata_s_inf,
  input  logic                  wlast_s_inf,
  input  logic                  wvalid_s_inf,
  output logic                  wready_s_inf,
  // write response
  output logic [ID_WIDTH-1:0]   bid_s_inf,
  output logic [1:0]            bresp_s_inf,
  output logic                  bvalid_s_inf,
  input  logic                  bready_s_inf,
  // read address
  input  logic [ID_WIDTH-1:0]   arid_s_inf,
  input  logic [ADDR_WIDTH-1:0] araddr_s_inf,
  input  logic [3:0]            arlen_s_inf,
  input  logic [2:0]            arsize_s_inf,
  input  logic [1:0]            arburst_s_inf,
  input  logic                  arvalid_s_inf,
  output logic                  arready_s_inf,
  // read data
  output logic [ID_WIDTH-1:0]   rid_s_inf,
  output logic [DATA_WIDTH-1:0] rdata_s_inf,
  output logic [1:0]            rresp_s_inf,
  output logic                  rlast_s_inf,
  output logic                  rvalid_s_inf,
  input  logic                  rready_s_inf
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = $clog2(MEM_WORDS);
  localparam logic [IDX_W-1:0] MEM_WORDS_IDX = IDX_W'(MEM_WORDS);

  // Byte-lane bits are ignored: every access is a full word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr_s_inf[1:0], awaddr_s_inf[1:0]};

  // ---------------- memory ----------------
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_waddr;
  logic                  mem_re;
  logic [MEM_AW-1:0]     mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  mem_1r1w #(
    .WORDS (MEM_WORDS),
    .WIDTH (DATA_WIDTH),
    .AW    (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wdata_s_inf),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // ---------------- read channel ----------------
  r_state_e             r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]  rid_q, rid_d;
  logic [IDX_W-1:0]     r_idx_q, r_idx_d;
  logic [3:0]           r_len_q, r_len_d;
  logic [3:0]           r_beat_q, r_beat_d;
  logic                 r_fmt_err_q, r_fmt_err_d;
  logic                 r_beat_err_q, r_beat_err_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rlast_q, rlast_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 r_load;
  logic [IDX_W-1:0]     r_load_idx;
  logic                 r_load_fmt;

  always_comb begin
    r_state_d    = r_state_q;
    rid_d        = rid_q;
    r_idx_d      = r_idx_q;
    r_len_d      = r_len_q;
    r_beat_d     = r_beat_q;
    r_fmt_err_d  = r_fmt_err_q;
    r_beat_err_d = r_beat_err_q;
    rvalid_d     = rvalid_q;
    rlast_d      = rlast_q;
    rresp_d      = rresp_q;
    r_load       = 1'b0;
    r_load_idx   = r_idx_q;
    r_load_fmt   = r_fmt_err_q;
    mem_re       = 1'b0;
    mem_raddr    = '0;

    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid_s_inf) begin
          rid_d       = arid_s_inf;
          r_len_d     = arlen_s_inf;
          r_beat_d    = 4'd0;
          r_fmt_err_d = fmt_err(arsize_s_inf, arburst_s_inf);
          r_load      = 1'b1;
          r_load_idx  = araddr_s_inf[ADDR_WIDTH-1:2];
          r_load_fmt  = r_fmt_err_d;
          rvalid_d    = 1'b1;
          rlast_d     = (arlen_s_inf == 4'd0);
          r_state_d   = R_BURST;
        end
      end
      R_BURST: begin
        if (rvalid_q && rready_s_inf) begin
          if (rlast_q) begin
            rvalid_d     = 1'b0;
            rlast_d      = 1'b0;
            rresp_d      = AXI_RESP_OKAY;
            r_beat_err_d = 1'b0;
            r_state_d    = R_IDLE;
          end else begin
            r_load     = 1'b1;
            r_load_idx = r_idx_q + IDX_W'(1);
            r_beat_d   = r_beat_q + 4'd1;
            rlast_d    = ((r_beat_q + 4'd1) == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    // Loading a beat fetches the next word; the RAM output register then holds
    // it until the following load, which keeps rdata stable under back-pressure.
    if (r_load) begin
      r_idx_d      = r_load_idx;
      r_beat_err_d = r_load_fmt || (r_load_idx >= MEM_WORDS_IDX);
      rresp_d      = r_beat_err_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      mem_re       = !r_beat_err_d;
      mem_raddr    = r_load_idx[MEM_AW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q    <= R_IDLE;
      rid_q        <= '0;
      r_idx_q      <= '0;
      r_len_q      <= '0;
      r_beat_q     <= '0;
      r_fmt_err_q  <= 1'b0;
      r_beat_err_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rresp_q      <= AXI_RESP_OKAY;
    end else begin
      r_state_q    <= r_state_d;
      rid_q        <= rid_d;
      r_idx_q      <= r_idx_d;
      r_len_q      <= r_len_d;
      r_beat_q     <= r_beat_d;
      r_fmt_err_q  <= r_fmt_err_d;
      r_beat_err_q <= r_beat_err_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      rresp_q      <= rresp_d;
    end
  end

  assign arready_s_inf = (r_state_q == R_IDLE);
  assign rvalid_s_inf  = rvalid_q;
  assign rlast_s_inf   = rlast_q;
  assign rresp_s_inf   = rresp_q;
  assign rid_s_inf     = rid_q;
  // Error beats and idle cycles present zero instead of stale RAM output.
  assign rdata_s_inf   = (rvalid_q && !r_beat_err_q) ? mem_rdata : '0;

  // ---------------- write channel ----------------
  w_state_e             w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]  wid_q, wid_d;
  logic [IDX_W-1:0]     w_idx_q, w_idx_d;
  logic [3:0]           w_len_q, w_len_d;
  logic [3:0]           w_beat_q, w_beat_d;
  logic                 w_fmt_err_q, w_fmt_err_d;
  logic                 w_err_q, w_err_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [ID_WIDTH-1:0]  bid_q, bid_d;
  logic                 w_oor;
  logic                 w_cnt_last;
  logic                 w_beat_err;

  assign w_oor      = (w_idx_q >= MEM_WORDS_IDX);
  assign w_cnt_last = (w_beat_q == w_len_q);

  always_comb begin
    w_state_d   = w_state_q;
    wid_d       = wid_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_beat_d    = w_beat_q;
    w_fmt_err_d = w_fmt_err_q;
    w_err_d     = w_err_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    bid_d       = bid_q;
    mem_we      = 1'b0;
    mem_waddr   = w_idx_q[MEM_AW-1:0];
    w_beat_err  = 1'b0;

    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid_s_inf) begin
          wid_d       = awid_s_inf;
          w_idx_d     = awaddr_s_inf[ADDR_WIDTH-1:2];
          w_len_d     = awlen_s_inf;
          w_beat_d    = 4'd0;
          w_fmt_err_d = fmt_err(awsize_s_inf, awburst_s_inf);
          w_err_d     = w_fmt_err_d;
          w_state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid_s_inf) begin
          // A beat is dropped when out of range or of unsupported format; a
          // mismatched wlast is still written but flags the burst.
          mem_we     = !w_oor && !w_fmt_err_q;
          w_beat_err = w_oor || w_fmt_err_q || (wlast_s_inf != w_cnt_last);
          w_err_d    = w_err_q || w_beat_err;
          if (wlast_s_inf || w_cnt_last) begin
            bvalid_d  = 1'b1;
            bresp_d   = w_err_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            bid_d     = wid_q;
            w_state_d = W_RESP;
          end else begin
            w_idx_d  = w_idx_q + IDX_W'(1);
            w_beat_d = w_beat_q + 4'd1;
          end
        end
      end
      W_RESP: begin
        if (bready_s_inf) begin
          bvalid_d  = 1'b0;
          bresp_d   = AXI_RESP_OKAY;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      wid_q       <= '0;
      w_idx_q     <= '0;
      w_len_q     <= '0;
      w_beat_q    <= '0;
      w_fmt_err_q <= 1'b0;
      w_err_q     <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= AXI_RESP_OKAY;
      bid_q       <= '0;
    end else begin
      w_state_q   <= w_state_d;
      wid_q       <= wid_d;
      w_idx_q     <= w_idx_d;
      w_len_q     <= w_len_d;
      w_beat_q    <= w_beat_d;
      w_fmt_err_q <= w_fmt_err_d;
      w_err_q     <= w_err_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      bid_q       <= bid_d;
    end
  end

  assign awready_s_inf = (w_state_q == W_IDLE);
  assign wready_s_inf  = (w_state_q == W_DATA);
  assign bvalid_s_inf  = bvalid_q;
  assign bresp_s_inf   = bresp_q;
  assign bid_s_inf     = bid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed testbench for axi_slave_mem. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, half a cycle from the DUT edge.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk           (clk),
    .rst           (rst),
    .awid_s_inf    (awid),
    .awaddr_s_inf  (awaddr),
    .awlen_s_inf   (awlen),
    .awsize_s_inf  (awsize),
    .awburst_s_inf (awburst),
    .awvalid_s_inf (awvalid),
    .awready_s_inf (awready),
    .wdata_s_inf   (wdata),
    .wlast_s_inf   (wlast),
    .wvalid_s_inf  (wvalid),
    .wready_s_inf  (wready),
    .bid_s_inf     (bid),
    .bresp_s_inf   (bresp),
    .bvalid_s_inf  (bvalid),
    .bready_s_inf  (bready),
    .arid_s_inf    (arid),
    .araddr_s_inf  (araddr),
    .arlen_s_inf   (arlen),
    .arsize_s_inf  (arsize),
    .arburst_s_inf (arburst),
    .arvalid_s_inf (arvalid),
    .arready_s_inf (arready),
    .rid_s_inf     (rid),
    .rdata_s_inf   (rdata),
    .rresp_s_inf   (rresp),
    .rlast_s_inf   (rlast),
    .rvalid_s_inf  (rvalid),
    .rready_s_inf  (rready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input string tag, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b1;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_awready"}, 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input string tag, input logic [31:0] data, input logic last);
    int n = 0;
    wdata = data; wlast = last; wvalid = 1'b1;
    while (!wready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_wready"}, 32'(wready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(bresp), 32'(resp));
    check({tag, "_bid"}, 32'(bid), 32'(id));
    @(negedge clk);
    bready = 1'b0;
    $display("[TB] %s: B id=%0h resp=%0d", tag, bid, bresp);
  endtask

  task automatic send_ar(input string tag, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len);
    int n = 0;
    arid = id; araddr = addr; arlen = len; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_arready"}, 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic get_r(input string tag, input logic [3:0] id, input logic [31:0] data,
                       input logic [1:0] resp, input logic last);
    int n = 0;
    rready = 1'b1;
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, data);
    check({tag, "_rresp"}, 32'(rresp), 32'(resp));
    check({tag, "_rlast"}, 32'(rlast), 32'(last));
    check({tag, "_rid"}, 32'(rid), 32'(id));
    $display("[TB] %s: R id=%0h data=%08h resp=%0d last=%0d", tag, rid, rdata, rresp, rlast);
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_ids",     32'({bid, rid}), 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    $display("[TB] reset state checked");
    rst = 1'b0;
    @(negedge clk);

    // W data offered before AW is not accepted
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wlast = 1'b1;
    @(negedge clk);
    check("early_w_wready", 32'(wready), 32'd0);
    wvalid = 1'b0; wlast = 1'b0;

    // 1: single-beat write and read
    send_aw("t1", 4'h3, 32'h10, 4'd0);
    send_w("t1", 32'h1234_5678, 1'b1);
    get_b("t1", 4'h3, 2'b00);
    send_ar("t1", 4'h5, 32'h10, 4'd0);
    get_r("t1", 4'h5, 32'h1234_5678, 2'b00, 1'b1);

    // 2: 4-beat burst, read back with rready toggling 1,0,1,0
    send_aw("t2", 4'h1, 32'h100, 4'd3);
    for (int b = 0; b < 4; b++) send_w("t2", 32'(b + 1), b == 3);
    get_b("t2", 4'h1, 2'b00);
    send_ar("t2", 4'h2, 32'h100, 4'd3);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        rready = 1'b0;
        check("t2_stall_rvalid", 32'(rvalid), 32'd1);
        check("t2_stall_rdata", rdata, 32'(b + 1));
        check("t2_stall_rlast", 32'(rlast), 32'(b == 3));
        @(negedge clk);
      end
      rready = 1'b1;
      check("t2_rdata", rdata, 32'(b + 1));
      check("t2_rlast", 32'(rlast), 32'(b == 3));
      check("t2_rid", 32'(rid), 32'h2);
      $display("[TB] t2: beat %0d data=%08h last=%0d", b, rdata, rlast);
      @(negedge clk);
    end
    rready = 1'b0;
    check("t2_done_rvalid", 32'(rvalid), 32'd0);
    check("t2_done_arready", 32'(arready), 32'd1);

    // 3: end-of-array boundary
    send_aw("t3a", 4'h4, 32'h1FFC, 4'd0);
    send_w("t3a", 32'hCAFE_F00D, 1'b1);
    get_b("t3a", 4'h4, 2'b00);
    send_aw("t3b", 4'h4, 32'h0, 4'd0);
    send_w("t3b", 32'h1111_1111, 1'b1);
    get_b("t3b", 4'h4, 2'b00);
    send_ar("t3c", 4'h6, 32'h1FFC, 4'd1);
    get_r("t3c_b0", 4'h6, 32'hCAFE_F00D, 2'b00, 1'b0);
    get_r("t3c_b1", 4'h6, 32'h0, 2'b10, 1'b1);
    send_aw("t3d", 4'h9, 32'h2000, 4'd0);
    send_w("t3d", 32'hDEAD_BEEF, 1'b1);
    get_b("t3d", 4'h9, 2'b10);
    send_ar("t3e", 4'h1, 32'h0, 4'd0);
    get_r("t3e", 4'h1, 32'h1111_1111, 2'b00, 1'b1);
    send_ar("t3f", 4'h1, 32'h1FFC, 4'd0);
    get_r("t3f", 4'h1, 32'hCAFE_F00D, 2'b00, 1'b1);

    // 4: same-cycle read and write of word 0x40 (byte 0x100)
    send_aw("t4a", 4'h2, 32'h100, 4'd0);
    send_w("t4a", 32'h55, 1'b1);
    get_b("t4a", 4'h2, 2'b00);
    send_aw("t4b", 4'h2, 32'h100, 4'd0);
    wvalid = 1'b1; wdata = 32'hAA; wlast = 1'b1;
    arvalid = 1'b1; arid = 4'h7; araddr = 32'h100; arlen = 4'd0;
    check("t4_wready", 32'(wready), 32'd1);
    check("t4_arready", 32'(arready), 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    get_r("t4_collide", 4'h7, 32'h55, 2'b00, 1'b1);
    get_b("t4b", 4'h2, 2'b00);
    send_ar("t4c", 4'h7, 32'h100, 4'd0);
    get_r("t4c", 4'h7, 32'hAA, 2'b00, 1'b1);

    // 5: early wlast on the third beat of a 4-beat burst, B held without bready
    send_aw("t5", 4'hB, 32'h200, 4'd3);
    send_w("t5", 32'hA0, 1'b0);
    send_w("t5", 32'hA1, 1'b0);
    send_w("t5", 32'hA2, 1'b1);
    check("t5_wready_after", 32'(wready), 32'd0);
    check("t5_awready_resp", 32'(awready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      check("t5_bvalid_hold", 32'(bvalid), 32'd1);
      check("t5_bresp_hold", 32'(bresp), 32'd2);
      @(negedge clk);
    end
    get_b("t5", 4'hB, 2'b10);
    check("t5_awready_back", 32'(awready), 32'd1);
    send_ar("t5r", 4'h3, 32'h208, 4'd0);
    get_r("t5r", 4'h3, 32'hA2, 2'b00, 1'b1);

    // 6: reset in the middle of a read burst
    send_ar("t6", 4'h8, 32'h100, 4'd3);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rvalid", 32'(rvalid), 32'd0);
    check("t6_arready", 32'(arready), 32'd1);
    check("t6_rlast", 32'(rlast), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_ar("t6b", 4'hC, 32'h104, 4'd0);
    get_r("t6b", 4'hC, 32'd2, 2'b00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
